// File: rtl/led_pwm_mmio.sv
// Memory-mapped LED controller: 16-word register window, per-channel off/direct/blink/PWM
// modes driven from a shared tick prescaler. Read data is registered to match the data RAM.
module led_pwm_mmio #(
  parameter int                   ADDR_SIZE = 10,
  parameter int                   DATA_SIZE = 32,
  parameter int                   NUM_LEDS  = 8,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 10'h3F0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic [ADDR_SIZE-1:0] daddr,
  input  logic                 MemWrite,
  input  logic                 MemRead,
  input  logic [DATA_SIZE-1:0] ddata_w,
  output logic [DATA_SIZE-1:0] ddata_r,
  output logic                 rd_hit,
  output logic [NUM_LEDS-1:0]  LED
);

  localparam logic [3:0] OFF_CTRL     = 4'd0;
  localparam logic [3:0] OFF_MODE     = 4'd1;
  localparam logic [3:0] OFF_DIRECT   = 4'd2;
  localparam logic [3:0] OFF_PRESCALE = 4'd3;
  localparam logic [3:0] OFF_BLINK    = 4'd4;
  localparam int         DUTY_BASE    = 5;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_PWM    = 2'd3
  } led_mode_e;

  // Register file
  logic                  en;
  logic [2*NUM_LEDS-1:0] mode;
  logic [NUM_LEDS-1:0]   direct;
  logic [15:0]           prescale;
  logic [7:0]            blink_h;
  logic [7:0]            duty [NUM_LEDS];

  // Timebase
  logic [15:0] pc;
  logic [7:0]  pwm_cnt;
  logic [7:0]  bc;
  logic        phase;
  logic        tick;

  logic                 sel;
  logic [3:0]           off;
  logic                 wr;
  logic                 sync_wr;
  logic                 ps_wr;
  logic [DATA_SIZE-1:0] rd_val;
  logic [NUM_LEDS-1:0]  led_next;
  logic                 unused_bits;

  assign sel     = (daddr[ADDR_SIZE-1:4] == BASE_ADDR[ADDR_SIZE-1:4]);
  assign off     = daddr[3:0];
  assign wr      = MemWrite && sel;
  assign sync_wr = wr && (off == OFF_CTRL) && ddata_w[1];
  assign ps_wr   = wr && (off == OFF_PRESCALE);
  assign tick    = en && (pc == prescale);

  // Upper write-data bits have no backing storage in any register.
  assign unused_bits = ^ddata_w;

  // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
  always_comb begin
    rd_val = '0;
    case (off)
      OFF_CTRL:     rd_val[0]              = en;
      OFF_MODE:     rd_val[2*NUM_LEDS-1:0] = mode;
      OFF_DIRECT:   rd_val[NUM_LEDS-1:0]   = direct;
      OFF_PRESCALE: rd_val[15:0]           = prescale;
      OFF_BLINK:    rd_val[7:0]            = blink_h;
      default: begin
        for (int i = 0; i < NUM_LEDS; i++) begin
          if ((DUTY_BASE + i < 16) && (off == 4'(DUTY_BASE + i))) rd_val[7:0] = duty[i];
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the duty array is small and architecturally visible, so it is reset like any other register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      en       <= 1'b0;
      mode     <= '0;
      direct   <= '0;
      prescale <= '0;
      blink_h  <= '0;
      for (int i = 0; i < NUM_LEDS; i++) duty[i] <= '0;
    end else if (wr) begin
      case (off)
        OFF_CTRL:     en       <= ddata_w[0];
        OFF_MODE:     mode     <= ddata_w[2*NUM_LEDS-1:0];
        OFF_DIRECT:   direct   <= ddata_w[NUM_LEDS-1:0];
        OFF_PRESCALE: prescale <= ddata_w[15:0];
        OFF_BLINK:    blink_h  <= ddata_w[7:0];
        default: begin
          for (int i = 0; i < NUM_LEDS; i++) begin
            if ((DUTY_BASE + i < 16) && (off == 4'(DUTY_BASE + i))) duty[i] <= ddata_w[7:0];
          end
        end
      endcase
    end
  end

  // Counters sit at zero while disabled; SYNC restarts them all on its write edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc      <= '0;
      pwm_cnt <= '0;
      bc      <= '0;
      phase   <= 1'b0;
    end else if (!en || sync_wr) begin
      pc      <= '0;
      pwm_cnt <= '0;
      bc      <= '0;
      phase   <= 1'b0;
    end else begin
      if (tick || ps_wr) pc <= '0;
      else               pc <= pc + 16'd1;
      if (tick) begin
        pwm_cnt <= pwm_cnt + 8'd1;
        if (bc == blink_h) begin
          bc    <= '0;
          phase <= ~phase;
        end else begin
          bc <= bc + 8'd1;
        end
      end
    end
  end

  always_comb begin
    led_next = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      case (led_mode_e'(mode[2*i +: 2]))
        MODE_OFF:    led_next[i] = 1'b0;
        MODE_DIRECT: led_next[i] = direct[i];
        MODE_BLINK:  led_next[i] = phase;
        MODE_PWM:    led_next[i] = (pwm_cnt < duty[i]);
        default:     led_next[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) LED <= '0;
    else       LED <= en ? led_next : '0;
  end

  // Read data is sampled from pre-write register values, so a same-edge write is not visible yet.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ddata_r <= '0;
      rd_hit  <= 1'b0;
    end else begin
      ddata_r <= (MemRead && sel) ? rd_val : '0;
      rd_hit  <= MemRead && sel;
    end
  end

endmodule

// File: tb/tb_led_pwm_mmio.sv
// Bench for led_pwm_mmio: directed scenarios plus random bus traffic, all checked every cycle
// against a behavioural model of the register map, tick prescaler, PWM and blink timebase.
module tb_led_pwm_mmio;

  localparam int          N    = 8;
  localparam logic [9:0]  BASE = 10'h3F0;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  daddr;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ddata_w;
  logic [31:0] ddata_r;
  logic        rd_hit;
  logic [N-1:0] LED;

  led_pwm_mmio #(
    .ADDR_SIZE(10), .DATA_SIZE(32), .NUM_LEDS(N), .BASE_ADDR(BASE)
  ) dut (
    .CLK(CLK), .RESET(RESET), .daddr(daddr), .MemWrite(MemWrite), .MemRead(MemRead),
    .ddata_w(ddata_w), .ddata_r(ddata_r), .rd_hit(rd_hit), .LED(LED)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain values, timebase as integer counters.
  bit          m_en;
  logic [15:0] m_mode;
  logic [7:0]  m_direct;
  int          m_p, m_h;
  int          m_duty [N];
  int          m_pc, m_pwm, m_bc;
  bit          m_phase;
  logic [7:0]  exp_led;
  logic [31:0] exp_rd;
  bit          exp_hit;

  task automatic model_reset();
    m_en = 0; m_mode = '0; m_direct = '0; m_p = 0; m_h = 0;
    foreach (m_duty[i]) m_duty[i] = 0;
    m_pc = 0; m_pwm = 0; m_bc = 0; m_phase = 0;
    exp_led = '0; exp_rd = '0; exp_hit = 0;
  endtask

  function automatic logic [31:0] model_read(input int off);
    if (off == 0) return 32'(m_en);
    if (off == 1) return 32'(m_mode);
    if (off == 2) return 32'(m_direct);
    if (off == 3) return 32'(m_p);
    if (off == 4) return 32'(m_h);
    if (off >= 5 && off < 5 + N) return 32'(m_duty[off-5]);
    return 32'd0;
  endfunction

  task automatic model_edge(input bit we, input bit re, input logic [9:0] addr, input logic [31:0] wd);
    bit sel;
    int off;
    int md;
    bit tick;
    sel = (addr[9:4] == BASE[9:4]);
    off = int'(addr[3:0]);
    exp_hit = re && sel;
    exp_rd  = exp_hit ? model_read(off) : 32'd0;
    for (int i = 0; i < N; i++) begin
      md = int'(m_mode[2*i +: 2]);
      if (!m_en)        exp_led[i] = 1'b0;
      else if (md == 1) exp_led[i] = m_direct[i];
      else if (md == 2) exp_led[i] = m_phase;
      else if (md == 3) exp_led[i] = (m_pwm < m_duty[i]);
      else              exp_led[i] = 1'b0;
    end
    if (!m_en || (we && sel && off == 0 && wd[1])) begin
      m_pc = 0; m_pwm = 0; m_bc = 0; m_phase = 0;
    end else begin
      tick = (m_pc == m_p);
      m_pc = (tick || (we && sel && off == 3)) ? 0 : (m_pc + 1) % 65536;
      if (tick) begin
        m_pwm = (m_pwm + 1) % 256;
        if (m_bc == m_h) begin
          m_bc = 0;
          m_phase = !m_phase;
        end else begin
          m_bc = (m_bc + 1) % 256;
        end
      end
    end
    if (we && sel) begin
      if (off == 0)      m_en = wd[0];
      else if (off == 1) m_mode = wd[15:0];
      else if (off == 2) m_direct = wd[7:0];
      else if (off == 3) m_p = int'(wd[15:0]);
      else if (off == 4) m_h = int'(wd[7:0]);
      else if (off >= 5 && off < 5 + N) m_duty[off-5] = int'(wd[7:0]);
    end
  endtask

  // One bus cycle: drive, clock, update model, compare all outputs 1 ns after the edge.
  task automatic cycle(input bit we, input bit re, input logic [9:0] addr, input logic [31:0] wd);
    MemWrite = we; MemRead = re; daddr = addr; ddata_w = wd;
    @(posedge CLK);
    model_edge(we, re, addr, wd);
    #1;
    check("led", 32'(LED), 32'(exp_led));
    check("rd_hit", 32'(rd_hit), 32'(exp_hit));
    check("ddata_r", ddata_r, exp_rd);
  endtask

  task automatic wr(input int off, input logic [31:0] wd);
    cycle(1'b1, 1'b0, BASE + 10'(off), wd);
  endtask

  task automatic rd(input int off);
    cycle(1'b0, 1'b1, BASE + 10'(off), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic count_led(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      idle(1);
      if (LED[ch]) cnt++;
    end
  endtask

  initial begin
    int cnt;
    int off;
    int r;
    logic [9:0]  a;
    logic [31:0] d;
    bit we, re;

    RESET = 1'b1; MemWrite = 0; MemRead = 0; daddr = '0; ddata_w = '0;
    model_reset();
    #2;
    check("reset_led", 32'(LED), 32'd0);
    check("reset_hit", 32'(rd_hit), 32'd0);
    #10 RESET = 1'b0;

    // Register access and direct mode
    wr(1, 32'h5555);
    wr(2, 32'hA5);
    wr(0, 32'h1);
    idle(1);
    check("direct_led", 32'(LED), 32'hA5);
    rd(2);
    check("rd_direct", ddata_r, 32'h0000_00A5);
    check("rd_direct_hit", 32'(rd_hit), 32'd1);
    rd(15);
    check("rd_off15", ddata_r, 32'd0);

    // Asynchronous reset between edges, with a read result on the bus
    wr(2, 32'hFF);
    idle(1);
    check("led_ff", 32'(LED), 32'hFF);
    rd(2);
    #2 RESET = 1'b1;
    #1;
    check("arst_led", 32'(LED), 32'd0);
    check("arst_rd", ddata_r, 32'd0);
    check("arst_hit", 32'(rd_hit), 32'd0);
    model_reset();
    MemRead = 0;
    #1 RESET = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(i);
      check($sformatf("post_rst_reg%0d", i), ddata_r, 32'd0);
    end

    // Decode isolation
    wr(2, 32'h3C);
    cycle(1'b1, 1'b0, 10'h3E2, 32'h11);
    rd(2);
    check("iso_direct", ddata_r, 32'h3C);
    cycle(1'b0, 1'b1, 10'h3E2, 32'd0);
    check("iso_hit", 32'(rd_hit), 32'd0);
    check("iso_rd", ddata_r, 32'd0);

    // Blink: tick every 2 cycles, half-period 3 ticks -> toggle every 6 cycles after SYNC
    wr(3, 32'd1);
    wr(4, 32'd2);
    wr(1, 32'h2);
    wr(0, 32'h1);
    idle(9);
    wr(0, 32'h3);
    for (int k = 1; k <= 18; k++) begin
      idle(1);
      check($sformatf("blink_k%0d", k), 32'(LED[0]), 32'(((k - 1) / 6) % 2));
    end

    // PWM at full tick rate
    wr(3, 32'd0);
    wr(5 + 3, 32'd64);
    wr(1, 32'h3 << 6);
    wr(0, 32'h3);
    count_led(3, 256, cnt);
    check("pwm64_count", 32'(cnt), 32'd64);
    wr(5 + 3, 32'd0);
    idle(1);
    count_led(3, 256, cnt);
    check("pwm0_count", 32'(cnt), 32'd0);
    wr(5 + 3, 32'd255);
    idle(1);
    count_led(3, 256, cnt);
    check("pwm255_count", 32'(cnt), 32'd255);

    // Same-cycle read and write returns the old value
    wr(5, 32'd10);
    cycle(1'b1, 1'b1, BASE + 10'd5, 32'd20);
    check("raw_old", ddata_r, 32'd10);
    rd(5);
    check("raw_new", ddata_r, 32'd20);

    // EN cleared mid-PWM, then re-enabled: counters start over from 0
    wr(5 + 3, 32'd64);
    idle(37);
    wr(0, 32'h0);
    idle(1);
    check("en_off_led", 32'(LED), 32'd0);
    idle(20);
    wr(0, 32'h1);
    count_led(3, 64, cnt);
    check("reen_high64", 32'(cnt), 32'd64);
    idle(1);
    check("reen_low65", 32'(LED[3]), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      we = (r < 25);
      re = ($urandom_range(0, 99) < 35);
      if ($urandom_range(0, 9) == 0) a = 10'($urandom_range(0, 1023));
      else                           a = BASE + 10'($urandom_range(0, 15));
      off = int'(a[3:0]);
      d = $urandom;
      if (off == 0)      d = {30'd0, ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) < 85)};
      else if (off == 3) d = 32'($urandom_range(0, 4));
      else if (off == 4) d = 32'($urandom_range(0, 3));
      cycle(we, re, a, d);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
